// File: rtl/axilite_arbiter_2to1.sv
// Two-requester AXI-Lite arbiter: round-robin grant of a single master port,
// one transaction (write or read) in flight at a time.
module axilite_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_aresetn,
    // requester side, index i = requester i
    input  logic [1:0]                  s_axi_awvalid,
    output logic [1:0]                  s_axi_awready,
    input  logic [2*ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [1:0]                  s_axi_wvalid,
    output logic [1:0]                  s_axi_wready,
    input  logic [2*DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [2*DATA_WIDTH/8-1:0]   s_axi_wstrb,
    output logic [1:0]                  s_axi_bvalid,
    input  logic [1:0]                  s_axi_bready,
    output logic [3:0]                  s_axi_bresp,
    input  logic [1:0]                  s_axi_arvalid,
    output logic [1:0]                  s_axi_arready,
    input  logic [2*ADDR_WIDTH-1:0]     s_axi_araddr,
    output logic [1:0]                  s_axi_rvalid,
    input  logic [1:0]                  s_axi_rready,
    output logic [2*DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [3:0]                  s_axi_rresp,
    // shared master port
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [ADDR_WIDTH-1:0]       m_axi_awaddr,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    output logic [DATA_WIDTH-1:0]       m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]     m_axi_wstrb,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    input  logic [1:0]                  m_axi_bresp,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    input  logic [DATA_WIDTH-1:0]       m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    output logic                        grant_id,
    output logic                        busy
);

    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_grant;
    logic   r_rr_ptr;
    logic   r_aw_done;
    logic   r_w_done;
    logic   w_grant_nxt;
    logic   w_rr_nxt;
    logic   w_aw_done_nxt;
    logic   w_w_done_nxt;

    logic [1:0]              w_req;
    logic                    w_winner;
    logic                    w_awvalid_g;
    logic                    w_wvalid_g;
    logic                    w_arvalid_g;
    logic                    w_bready_g;
    logic                    w_rready_g;
    logic [ADDR_WIDTH-1:0]   w_awaddr_g;
    logic [ADDR_WIDTH-1:0]   w_araddr_g;
    logic [DATA_WIDTH-1:0]   w_wdata_g;
    logic [STRB_W-1:0]       w_wstrb_g;

    // Place a single handshake bit into the granted requester's lane.
    function automatic logic [1:0] steer(input logic sel, input logic val);
        steer = sel ? {val, 1'b0} : {1'b0, val};
    endfunction

    assign w_req    = s_axi_awvalid | s_axi_arvalid;
    assign w_winner = w_req[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;

    assign w_awvalid_g = s_axi_awvalid[r_grant];
    assign w_wvalid_g  = s_axi_wvalid[r_grant];
    assign w_arvalid_g = s_axi_arvalid[r_grant];
    assign w_bready_g  = s_axi_bready[r_grant];
    assign w_rready_g  = s_axi_rready[r_grant];
    assign w_awaddr_g  = r_grant ? s_axi_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axi_awaddr[ADDR_WIDTH-1:0];
    assign w_araddr_g  = r_grant ? s_axi_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axi_araddr[ADDR_WIDTH-1:0];
    assign w_wdata_g   = r_grant ? s_axi_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : s_axi_wdata[DATA_WIDTH-1:0];
    assign w_wstrb_g   = r_grant ? s_axi_wstrb[2*STRB_W-1:STRB_W] : s_axi_wstrb[STRB_W-1:0];

    assign grant_id = r_grant;
    assign busy     = (r_state != ST_IDLE);

    // State, grant, round-robin pointer and write-handshake flags.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state   <= ST_IDLE;
            r_grant   <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

    // Next-state logic and channel routing between the granted requester and the master port.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_rr_nxt      = r_rr_ptr;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        s_axi_awready = 2'b00;
        s_axi_wready  = 2'b00;
        s_axi_bvalid  = 2'b00;
        s_axi_bresp   = 4'b0000;
        s_axi_arready = 2'b00;
        s_axi_rvalid  = 2'b00;
        s_axi_rdata   = {(2*DATA_WIDTH){1'b0}};
        s_axi_rresp   = 4'b0000;
        m_axi_awvalid = 1'b0;
        m_axi_awaddr  = {ADDR_WIDTH{1'b0}};
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = {DATA_WIDTH{1'b0}};
        m_axi_wstrb   = {STRB_W{1'b0}};
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = {ADDR_WIDTH{1'b0}};
        m_axi_rready  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_grant_nxt = w_winner;
                    if (s_axi_awvalid[w_winner]) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // A channel whose handshake already completed stays silent until WRESP.
                m_axi_awvalid = w_awvalid_g & ~r_aw_done;
                m_axi_awaddr  = r_aw_done ? {ADDR_WIDTH{1'b0}} : w_awaddr_g;
                m_axi_wvalid  = w_wvalid_g & ~r_w_done;
                m_axi_wdata   = r_w_done ? {DATA_WIDTH{1'b0}} : w_wdata_g;
                m_axi_wstrb   = r_w_done ? {STRB_W{1'b0}} : w_wstrb_g;
                s_axi_awready = steer(r_grant, m_axi_awready & ~r_aw_done);
                s_axi_wready  = steer(r_grant, m_axi_wready & ~r_w_done);
                w_aw_done_nxt = r_aw_done | (w_awvalid_g & m_axi_awready);
                w_w_done_nxt  = r_w_done | (w_wvalid_g & m_axi_wready);
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt = ST_WRESP;
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRESP: begin
                s_axi_bvalid = steer(r_grant, m_axi_bvalid);
                s_axi_bresp  = r_grant ? {m_axi_bresp, 2'b00} : {2'b00, m_axi_bresp};
                m_axi_bready = w_bready_g;
                if (m_axi_bvalid && w_bready_g) begin
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_rr_nxt      = ~r_grant;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WRESP;
                end
            end
            ST_READ: begin
                m_axi_arvalid = w_arvalid_g;
                m_axi_araddr  = w_araddr_g;
                s_axi_arready = steer(r_grant, m_axi_arready);
                if (w_arvalid_g && m_axi_arready) begin
                    w_state_nxt = ST_RDATA;
                end else begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_RDATA: begin
                s_axi_rvalid = steer(r_grant, m_axi_rvalid);
                s_axi_rdata  = r_grant ? {m_axi_rdata, {DATA_WIDTH{1'b0}}} : {{DATA_WIDTH{1'b0}}, m_axi_rdata};
                s_axi_rresp  = r_grant ? {m_axi_rresp, 2'b00} : {2'b00, m_axi_rresp};
                m_axi_rready = w_rready_g;
                if (m_axi_rvalid && w_rready_g) begin
                    w_rr_nxt    = ~r_grant;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RDATA;
                end
            end
            default: begin
                w_aw_done_nxt = 1'b0;
                w_w_done_nxt  = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/axilite_arbiter_2to1.md
AXILITE_ARBITER_2TO1 -- requirements
Module: axilite_arbiter_2to1

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI-Lite address width on all ports.
REQ-002 Parameter DATA_WIDTH, default 32, AXI-Lite data width on all ports; WSTRB width DATA_WIDTH/8.
REQ-003 s_axi_aclk  in  1  clock; all logic on rising edge.
REQ-004 s_axi_aresetn  in  1  reset, asynchronous, active-low.
REQ-005 s_axi_aw{valid,ready}[1:0], s_axi_awaddr[2*ADDR_WIDTH-1:0]  in/out/in  requester write-address channels; index i = requester i.
REQ-006 s_axi_w{valid,ready}[1:0], s_axi_wdata[2*DATA_WIDTH-1:0], s_axi_wstrb[2*DATA_WIDTH/8-1:0]  in/out/in/in  requester write-data channels.
REQ-007 s_axi_b{valid,ready}[1:0], s_axi_bresp[3:0]  out/in/out  requester write-response channels.
REQ-008 s_axi_ar{valid,ready}[1:0], s_axi_araddr[2*ADDR_WIDTH-1:0]  in/out/in  requester read-address channels.
REQ-009 s_axi_r{valid,ready}[1:0], s_axi_rdata[2*DATA_WIDTH-1:0], s_axi_rresp[3:0]  out/in/out/out  requester read-data channels.
REQ-010 m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  mirror of one requester port, reversed directions  single AXI-Lite master port to the shared memory slave.
REQ-011 grant_id  out  1  index of the requester currently owning the master port.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 States: IDLE, WRITE (AW/W forwarding), WRESP, READ (AR forwarding), RDATA.
REQ-014 One transaction at a time on the master port; no overlap of reads and writes.
REQ-015 Requester i requests when s_axi_awvalid[i] or s_axi_arvalid[i] is high.
REQ-016 IDLE arbitration: round-robin between requesters; rr_ptr marks the preferred requester; if only one requests, it wins.
REQ-017 Within the winning requester, a write (awvalid) takes priority over a read (arvalid).
REQ-018 Grant registered in IDLE; next state WRITE or READ; forwarding starts the following cycle (1-cycle arbitration latency).
REQ-019 In IDLE, all requester ready/valid outputs and all m_axi valid/ready outputs are 0.
REQ-020 WRITE: m_axi_awvalid/awaddr and m_axi_wvalid/wdata/wstrb combinationally follow the granted requester until each handshake completes; awready/wready pass back to that requester only.
REQ-021 WRITE: aw_done and w_done flags track completed handshakes in either order or the same cycle; after completion the channel's m-side valid is forced 0; transition to WRESP when both are set.
REQ-022 WRESP: m_axi_bvalid/bresp pass to the granted requester; m_axi_bready = s_axi_bready[grant_id]; on handshake, clear flags, go IDLE.
REQ-023 READ: m_axi_arvalid/araddr follow granted requester; on AR handshake go RDATA.
REQ-024 RDATA: m_axi_rvalid/rdata/rresp pass to granted requester; m_axi_rready = s_axi_rready[grant_id]; on handshake go IDLE.
REQ-025 Non-granted requester: all ready and valid outputs held 0; data/resp outputs 0.
REQ-026 Responses (bresp/rresp, including SLVERR/DECERR) forwarded unmodified.
REQ-027 rr_ptr updates to ~grant_id on the final response handshake only; unchanged otherwise.
REQ-028 A requester that deasserts valid before grant forwarding is not an error; if the granted valid is low on entering WRITE/READ, the state waits (requesters must not retract valid per AXI; no timeout).
REQ-029 Back-pressure from bready/rready low holds WRESP/RDATA indefinitely with m_axi_bvalid/rvalid held by the slave.

Reset
REQ-030 On s_axi_aresetn low: state IDLE, rr_ptr 0, grant_id 0, aw_done/w_done 0, busy 0, every valid/ready output 0, data/resp outputs 0; takes effect immediately, including mid-transaction (transaction abandoned, no response generated).
REQ-031 First arbitration after reset with both requesting grants requester 0.

Verification
REQ-032 Single write: req0 AW 0x10 + W 0xDEADBEEF strb 0xF -> m-port AW/W carry same values one cycle after request, req0 gets bresp 00, busy low after B handshake, read-back by req1 returns 0xDEADBEEF.
REQ-033 Contention: both requesters write each cycle continuously -> grants alternate 0,1,0,1; no requester served twice consecutively while the other waits.
REQ-034 W before AW: req1 W in cycle n, AW in cycle n+3 -> single m-port transaction, WRESP entered only after AW handshake, req1 bresp 00.
REQ-035 Same requester AW and AR simultaneously -> write served first, read next arbitration; read returns newly written data.
REQ-036 Back-pressure: rready[0] low 5 cycles in RDATA -> rvalid[0] held, rdata stable, req1 request waits, grant switches only after handshake.
REQ-037 Reset asserted in WRESP -> all outputs 0 same cycle; after release, both requesting -> requester 0 granted; out-of-range address 0x400 -> rresp 11 forwarded to requester.
